wand_arb_tx: RTL and testbench

WAND_ARB_TX -- requirements
Module: wand_arb_tx

---
 rtl/wand_pkg.sv | 36 +++
 rtl/wand_bit_timer.sv | 32 +++
 rtl/wand_arb_tx.sv | 144 ++++++++++++++
 tb/tb_wand_arb_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wand_pkg.sv
// Shared types and constants for the wired-AND arbitrating transmitter.
// WAND_TX_PARITY_EN adds an even-parity bit after the payload.
package wand_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } wand_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_BIT_CYCLES = 4;

`ifdef WAND_TX_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Logical bit value placed on the line for a given frame position.
  function automatic logic tx_bit(input wand_state_t s, input logic data_msb,
                                  input logic par);
    logic b;
    b = 1'b1;
    case (s)
      S_START:  b = 1'b0;
      S_DATA:   b = data_msb;
      S_PARITY: b = par;
      default:  b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wand_bit_timer.sv
// Bit-time counter: runs 0..BIT_CYCLES-1 and flags the mid-bit sample point
// and the last cycle of each bit.
module wand_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic sample,
  output logic bit_end
);

  localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BIT_CYCLES / 2);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign sample  = (count == CNT_MID) && !clr;
  assign bit_end = (count == CNT_LAST) && !clr;

endmodule

// File: rtl/wand_arb_tx.sv
// Wired-AND bus transmitter with bitwise arbitration and receive-back.
// Optional even parity bit controlled by WAND_TX_PARITY_EN.
module wand_arb_tx
  import wand_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              bus_in,
  output logic              drive_low,
  output logic              busy,
  output logic              done,
  output logic              arb_lost,
  output logic              frame_err,
  output logic [DATA_W-1:0] rx_data,
  output wand_state_t       fsm_state
);

  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  // Handshake: start is taken in the cycle it is high while IDLE, the line is
  // recessive and no done pulse is showing; anything else is dropped. done is
  // a one-cycle completion strobe, and busy covers every cycle in between.

  wand_state_t       state, state_nxt;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] tx_sr, tx_sr_nxt;
  logic [DATA_W-1:0] rx_nxt;
  logic              par_bit, par_nxt;
  logic              lost_nxt, ferr_nxt, done_nxt, busy_nxt, drive_nxt;
  logic              accept, cur_bit;
  logic              sample, bit_end;

  wand_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == S_IDLE),
    .sample (sample),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_idx   <= '0;
      tx_sr     <= '0;
      par_bit   <= 1'b0;
      rx_data   <= '0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      arb_lost  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_idx_nxt;
      tx_sr     <= tx_sr_nxt;
      par_bit   <= par_nxt;
      rx_data   <= rx_nxt;
      drive_low <= drive_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      arb_lost  <= lost_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    tx_sr_nxt   = tx_sr;
    par_nxt     = par_bit;
    rx_nxt      = rx_data;
    lost_nxt    = arb_lost;
    ferr_nxt    = frame_err;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    accept      = (state == S_IDLE) && start && bus_in && !done;
    cur_bit     = tx_bit(state, tx_sr[DATA_W-1], par_bit);

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt   = S_START;
          tx_sr_nxt   = data_in;
          par_nxt     = ^data_in;
          bit_idx_nxt = '0;
          lost_nxt    = 1'b0;
          ferr_nxt    = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        // Sampling continues after a loss so rx_data ends up with the winner's payload.
        if (sample) begin
          rx_nxt = {rx_data[DATA_W-2:0], bus_in};
          if (cur_bit && !bus_in) lost_nxt = 1'b1;
        end
        if (bit_end) begin
          tx_sr_nxt   = tx_sr << 1;
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) begin
            bit_idx_nxt = '0;
`ifdef WAND_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (sample && cur_bit && !bus_in) lost_nxt = 1'b1;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (sample && !bus_in) ferr_nxt = 1'b1;
        if (bit_end) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Registered line drive follows the bit of the upcoming cycle.
    drive_nxt = (state_nxt != S_IDLE) && !lost_nxt &&
                !tx_bit(state_nxt, tx_sr_nxt[DATA_W-1], par_nxt);
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_wand_arb_tx.sv
// Directed bench for wand_arb_tx with a wired-AND bus model and a done-driven scoreboard.
// Honours WAND_TX_PARITY_EN for expected latency and the parity-bit check.
module tb_wand_arb_tx;
  import wand_pkg::*;

  localparam int W  = 8;
  localparam int BC = 4;
`ifdef WAND_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int LAT = (W + 2 + PBITS) * BC + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         bus_in;
  logic         drive_low, busy, done, arb_lost, frame_err;
  logic [W-1:0] rx_data;
  wand_state_t  fsm_state;

  wand_arb_tx #(.DATA_W(W), .BIT_CYCLES(BC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .bus_in   (bus_in),
    .drive_low(drive_low),
    .busy     (busy),
    .done     (done),
    .arb_lost (arb_lost),
    .frame_err(frame_err),
    .rx_data  (rx_data),
    .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // wired-AND bus: DUT, optional competitor, stop-bit forcing, idle pull-down
  int           acc_cyc = -1000;
  logic         comp_en = 1'b0;
  logic [W-1:0] comp_data = '0;
  logic         force_stop = 1'b0;
  logic         idle_low = 1'b0;
  int           k, bidx;
  logic         comp_bit;

  always_comb begin
    k        = cyc - acc_cyc;
    bidx     = (k - 1) / BC;
    comp_bit = 1'b1;
    if (k >= 1 && bidx == 0) comp_bit = 1'b0;
    else if (k >= 1 && bidx >= 1 && bidx <= W) comp_bit = comp_data[W - bidx];
    bus_in = ~drive_low & ~(comp_en & ~comp_bit) &
             ~(force_stop && k >= 1 && bidx == W + 1 + PBITS) & ~idle_low;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 want=0 (cycle %0d)", cyc);
      end else begin
        logic [W+1:0] e;
        int           c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("rx_data", rx_data, e[W+1:2]);
        check("arb_lost", arb_lost, e[1]);
        check("frame_err", frame_err, e[0]);
        check("done_latency", cyc, c);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] d, input logic cen, input logic [W-1:0] cd,
                      input logic fs, input logic push, input logic [W-1:0] erx,
                      input logic eal, input logic efe);
    @(negedge clk);
    start      = 1'b1;
    data_in    = d;
    comp_en    = cen;
    comp_data  = cd;
    force_stop = fs;
    acc_cyc    = cyc;
    if (push) begin
      exp_q.push_back({erx, eal, efe});
      exp_cyc_q.push_back(cyc + LAT);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_k(input int kk);
    while (cyc - acc_cyc < kk) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got=0 want=1 (cycle %0d)", cyc);
    end
  endtask

  initial begin
    int hi_cnt;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_drive_low", drive_low, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_arb_lost", arb_lost, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // solo frame 0xA5
    send(8'hA5, 0, 8'h00, 0, 1, 8'hA5, 0, 0);
    wait_k(1);
    check("start_bit_drive", drive_low, 1);
    check("busy_in_frame", busy, 1);
    wait_done();
    check("busy_on_done", busy, 0);
    // start on the done cycle must be dropped
    start   = 1'b1;
    data_in = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_ignored", busy, 0);

    // arbitration: 0xA5 vs 0x95, loss on payload bit 2
    send(8'hA5, 1, 8'h95, 0, 1, 8'h95, 1, 0);
    wait_k(15);
    check("arb_lost_before", arb_lost, 0);
    wait_k(16);
    check("arb_lost_after", arb_lost, 1);
    check("arb_drive_released", drive_low, 0);
    hi_cnt = 0;
    while (!done && cyc - acc_cyc < 200) begin
      @(negedge clk);
      if (drive_low) hi_cnt++;
    end
    check("arb_no_drive_to_end", hi_cnt, 0);
    wait_done();
    comp_en = 1'b0;

    // start during busy is ignored
    send(8'h3C, 0, 8'h00, 0, 1, 8'h3C, 0, 0);
    wait_k(10);
    start   = 1'b1;
    data_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_no_change", busy, 1);
    wait_done();
    @(negedge clk);

    // start with dominant bus in IDLE is ignored
    idle_low = 1'b1;
    start    = 1'b1;
    data_in  = 8'h11;
    @(negedge clk);
    start = 1'b0;
    check("idle_dominant_busy", busy, 0);
    check("idle_dominant_drive", drive_low, 0);
    idle_low = 1'b0;
    @(negedge clk);

    // stop-bit error, then cleared by the next accept
    send(8'h5A, 0, 8'h00, 1, 1, 8'h5A, 0, 1);
    wait_done();
    force_stop = 1'b0;
    @(negedge clk);
    check("frame_err_held", frame_err, 1);
    send(8'h81, 0, 8'h00, 0, 1, 8'h81, 0, 0);
    wait_k(1);
    check("frame_err_cleared", frame_err, 0);
    wait_done();

    // more payload patterns
    send(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0);
    wait_done();
    send(8'hFF, 0, 8'h00, 0, 1, 8'hFF, 0, 0);
    wait_done();

`ifdef WAND_TX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1 (recessive)
    send(8'h07, 0, 8'h00, 0, 1, 8'h07, 0, 0);
    wait_k((W + 1) * BC + 1);
    check("parity_bit_drive", drive_low, 0);
    wait_done();
`endif

    // reset mid-frame: bus released, no done pulse
    send(8'hC3, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    wait_k(20);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_drive_low", drive_low, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_state", fsm_state, S_IDLE);
    @(negedge clk);
    rst_n   = 1'b1;
    acc_cyc = -1000;
    repeat (60) @(negedge clk);
    check("post_reset_busy", busy, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
